cal_seq: RTL and testbench
==========================

# cal_seq

Calibration sequencer for the 16-bit saturating compensation datapath (Temp register, satAdd and satMult with their input and output muxes). On a start request it triggers one A2D conversion and waits for completion. It then drives the datapath selects, Temp enable and NV_MEM coefficient address through a fixed three-step computation: offset, gain, offset. It captures the final datapath result and signals completion.

## Interface
- `A2D_TMO`, default 1023: maximum number of CONV cycles to wait for `cnv_cmplt` before aborting.
- `NV_AW`, default 4: NV_MEM address width.
- `COEFF_BASE`, default 0: NV_MEM address of coeff0. coeff1 and coeff2 follow at +1 and +2.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `strt` in 1: request one calibrated conversion; ignored unless IDLE.
- `cnv_cmplt` in 1: A2D conversion done (A2D result valid on datapath `a2d`).
- `dst` in 16: datapath result.
- `strt_cnv` out 1: one-cycle pulse starting the A2D.
- `nv_addr` out NV_AW: NV_MEM read address. NV_MEM has 1-cycle read latency; `coeff` reflects the previous cycle's address.
- `selA2D` out 1: datapath A-side select.
- `selCoeff` out 1: datapath B-side select.
- `selMult` out 1: datapath dst select.
- `enTmp` out 1: Temp register write enable.
- `busy` out 1: high in any state other than IDLE.
- `rdy` out 1: one-cycle pulse; `result` is valid.
- `err` out 1: one-cycle pulse on A2D timeout.
- `result` out 16: registered calibrated value; holds until the next successful sequence.

## Operation
- FSM states are IDLE, CONV, OFST, GAIN, ADD2. The control outputs `sel*`, `enTmp`, `nv_addr` and `busy` are Moore outputs decoded from state.
- IDLE: all selects 0, `enTmp` 0, `nv_addr`=COEFF_BASE. On `strt`, go to CONV, clear the timeout counter and register `strt_cnv`=1 for exactly one cycle.
- CONV: `nv_addr`=COEFF_BASE, which pre-fetches coeff0, and controls stay idle.
  - The timeout counter increments once per CONV cycle.
  - If `cnv_cmplt`=1, go to OFST.
  - Else if the counter equals A2D_TMO, go to IDLE with `err` pulsed.
  - If `cnv_cmplt` and timeout coincide, `cnv_cmplt` wins.
- OFST: selA2D=1, selCoeff=1, selMult=0, enTmp=1, so Temp ← sat(a2d + coeff0). `nv_addr`=COEFF_BASE+1. Next state is GAIN.
- GAIN: selMult=1, enTmp=1, so Temp ← satMult(coeff1, Temp). `nv_addr`=COEFF_BASE+2. Next state is ADD2.
- ADD2: selA2D=0, selCoeff=1, selMult=0, enTmp=1, so Temp ← sat(Temp + coeff2). On the same edge `result` ← `dst`. Next state is IDLE with `rdy` pulsed.
- The sequencer performs no arithmetic. Saturation is owned by the datapath, and `result` is an exact copy of `dst` as sampled in ADD2.
- `strt` while `busy` is dropped, not queued.
- Reset mid-sequence: next state is IDLE, with no `rdy` and no `err`. `result` clears to 0.

## Timing
- Reset values: state IDLE; `strt_cnv`, `rdy`, `err`, `busy`, `enTmp`, `selA2D`, `selCoeff` and `selMult` all 0; `nv_addr`=COEFF_BASE; `result`=0; timeout counter 0.
- `strt` sampled high in cycle 0: CONV and `strt_cnv` are both high in cycle 1.
- `cnv_cmplt` sampled high in cycle k (k≥1): OFST in k+1, GAIN in k+2, ADD2 in k+3.
- `rdy` and the new `result` are visible in cycle k+4, where the state is IDLE again. A `strt` in cycle k+4 is accepted.
- Minimum `strt`→`rdy` latency is 5 cycles, reached when `cnv_cmplt` arrives in cycle 1.
- Timeout: with no `cnv_cmplt`, `err` is high in cycle A2D_TMO+1 and `busy` is low in that same cycle.
- `enTmp` is high for exactly 3 cycles per successful sequence and is never high in IDLE or CONV.

## Structure
- Package `cal_seq_pkg` holds:
  - the state enum `cal_state_t`;
  - the step offset constants `OFS0_IDX`=0, `GAIN_IDX`=1, `OFS2_IDX`=2;
  - a packed struct for the `{selA2D, selCoeff, selMult, enTmp}` control word.
- One sub-module, `a2d_tmo_cnt`: a clearable, enabled counter with a `tmo` compare output, parameterized by A2D_TMO.
- The FSM, output decode and result register live in `cal_seq`.

## Test plan
- Nominal sequence: reset, then `strt` at cycle 0 and `cnv_cmplt` at cycle 3.
  - strt_cnv is high only in cycle 1.
  - Control words {selA2D,selCoeff,selMult,enTmp} are 1101, 0011, 0101 in cycles 4, 5, 6.
  - nv_addr is 0, 1, 2 in cycles 3, 4, 5.
  - rdy is high in cycle 7.
- End-to-end value check: with a2d=0x0100, coeff0=0x0010, coeff1 and coeff2 from a model of the datapath, `result` equals the model's expected output. The 0x0110 offset-step value must also be seen in Temp after OFST.
- Timeout: with A2D_TMO=8 and `cnv_cmplt` held 0, `err` pulses in cycle 9, `rdy` never asserts, `enTmp` stays 0 and `result` keeps its previous value.
- Coincident events: `cnv_cmplt` asserted in the timeout cycle gives no `err` and a normal sequence. `strt` pulsed during GAIN is ignored, and only one `rdy` occurs.
- Reset in GAIN: the next cycle is IDLE with all outputs at reset values and no `rdy`. A fresh `strt` then completes normally.
- Back-to-back: a `strt` in the same cycle as `rdy` gives `strt_cnv` in the following cycle.

Source files
------------

// File: rtl/cal_seq_pkg.sv
// Shared types and constants for the calibration sequencer.
package cal_seq_pkg;

    // Sequencer states: wait, A2D conversion, then the three datapath steps.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CONV = 3'd1,
        ST_OFST = 3'd2,
        ST_GAIN = 3'd3,
        ST_ADD2 = 3'd4
    } cal_state_t;

    // Offsets of the three coefficients from the coefficient base address.
    localparam int OFS0_IDX = 0;
    localparam int GAIN_IDX = 1;
    localparam int OFS2_IDX = 2;

    // Datapath control word, in the order {selA2D, selCoeff, selMult, enTmp}.
    typedef struct packed {
        logic selA2D;
        logic selCoeff;
        logic selMult;
        logic enTmp;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = 4'b0000;
    localparam ctrl_word_t CTRL_OFST = 4'b1101;  // Temp <- sat(a2d + coeff0)
    localparam ctrl_word_t CTRL_GAIN = 4'b0011;  // Temp <- satMult(coeff1, Temp)
    localparam ctrl_word_t CTRL_ADD2 = 4'b0101;  // Temp <- sat(Temp + coeff2)

    // Control word driven to the datapath in each state.
    function automatic ctrl_word_t ctrlFor(input cal_state_t st);
        case (st)
            ST_OFST: return CTRL_OFST;
            ST_GAIN: return CTRL_GAIN;
            ST_ADD2: return CTRL_ADD2;
            default: return CTRL_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/cal_seq_if.sv
// Sequencer-to-datapath/host signal bundle.
interface cal_seq_if #(
    parameter int NV_AW = 4
);
    logic              strt;
    logic              cnv_cmplt;
    logic [15:0]       dst;
    logic              strt_cnv;
    logic [NV_AW-1:0]  nv_addr;
    logic              selA2D;
    logic              selCoeff;
    logic              selMult;
    logic              enTmp;
    logic              busy;
    logic              rdy;
    logic              err;
    logic [15:0]       result;

    // Sequencer side.
    modport master (
        input  strt, cnv_cmplt, dst,
        output strt_cnv, nv_addr, selA2D, selCoeff, selMult, enTmp,
               busy, rdy, err, result
    );

    // Host / datapath side.
    modport slave (
        output strt, cnv_cmplt, dst,
        input  strt_cnv, nv_addr, selA2D, selCoeff, selMult, enTmp,
               busy, rdy, err, result
    );
endinterface

// File: rtl/cal_seq_a2d_tmo_cnt.sv
// A2D timeout counter: cleared on a new request, counts CONV cycles.
module a2d_tmo_cnt #(
    parameter int TMO = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tmo
);
    localparam int CW = (TMO < 2) ? 1 : $clog2(TMO + 1);

    logic [CW-1:0] cntReg;

    // Count enabled cycles; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cntReg <= '0;
        end else if (en) begin
            cntReg <= cntReg + CW'(1);
        end
    end

    // Fires on the enabled cycle whose increment brings the count to TMO.
    assign tmo = en && (cntReg == CW'(TMO - 1));
endmodule

// File: rtl/cal_seq.sv
// Calibration sequencer: one A2D conversion, then offset/gain/offset steps.
module cal_seq
    import cal_seq_pkg::*;
#(
    parameter int A2D_TMO    = 1023,
    parameter int NV_AW      = 4,
    parameter int COEFF_BASE = 0
) (
    input  logic      clk,
    input  logic      rst,
    cal_seq_if.master bus
);
    cal_state_t      stateReg;
    cal_state_t      stateNext;
    ctrl_word_t      ctrl;
    logic [NV_AW-1:0] nvAddr;
    logic            busyDec;
    logic            cntClr;
    logic            cntEn;
    logic            tmoHit;
    logic            strtCnvReg, strtCnvNext;
    logic            rdyReg, rdyNext;
    logic            errReg, errNext;
    logic            ldResult;
    logic [15:0]     resultReg;

    assign cntEn = (stateReg == ST_CONV);

    a2d_tmo_cnt #(.TMO(A2D_TMO)) u_tmoCnt (
        .clk (clk),
        .rst (rst),
        .clr (cntClr),
        .en  (cntEn),
        .tmo (tmoHit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= ST_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic, pulse requests and Moore output decode.
    always_comb begin
        stateNext   = stateReg;
        cntClr      = 1'b0;
        strtCnvNext = 1'b0;
        rdyNext     = 1'b0;
        errNext     = 1'b0;
        ldResult    = 1'b0;
        ctrl        = ctrlFor(stateReg);
        nvAddr      = NV_AW'(COEFF_BASE + OFS0_IDX);
        busyDec     = (stateReg != ST_IDLE);
        case (stateReg)
            ST_IDLE: begin
                if (bus.strt) begin
                    stateNext   = ST_CONV;
                    cntClr      = 1'b1;
                    strtCnvNext = 1'b1;
                end
            end
            ST_CONV: begin
                // Completion wins over a coincident timeout.
                if (bus.cnv_cmplt) begin
                    stateNext = ST_OFST;
                end else if (tmoHit) begin
                    stateNext = ST_IDLE;
                    errNext   = 1'b1;
                end
            end
            ST_OFST: begin
                nvAddr    = NV_AW'(COEFF_BASE + GAIN_IDX);
                stateNext = ST_GAIN;
            end
            ST_GAIN: begin
                nvAddr    = NV_AW'(COEFF_BASE + OFS2_IDX);
                stateNext = ST_ADD2;
            end
            ST_ADD2: begin
                stateNext = ST_IDLE;
                rdyNext   = 1'b1;
                ldResult  = 1'b1;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Registered one-cycle pulses and the captured result.
    always_ff @(posedge clk) begin
        if (rst) begin
            strtCnvReg <= 1'b0;
            rdyReg     <= 1'b0;
            errReg     <= 1'b0;
            resultReg  <= '0;
        end else begin
            strtCnvReg <= strtCnvNext;
            rdyReg     <= rdyNext;
            errReg     <= errNext;
            if (ldResult) begin
                resultReg <= bus.dst;
            end
        end
    end

    assign bus.strt_cnv = strtCnvReg;
    assign bus.rdy      = rdyReg;
    assign bus.err      = errReg;
    assign bus.result   = resultReg;
    assign bus.busy     = busyDec;
    assign bus.nv_addr  = nvAddr;
    assign bus.selA2D   = ctrl.selA2D;
    assign bus.selCoeff = ctrl.selCoeff;
    assign bus.selMult  = ctrl.selMult;
    assign bus.enTmp    = ctrl.enTmp;
endmodule

// File: tb/tb_cal_seq.sv
// Bench for cal_seq with a behavioural model of the saturating datapath.
module tb_cal_seq;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    logic [15:0] nvMem [16];
    logic [15:0] a2d = 16'h0;
    logic [15:0] coeffQ = 16'h0;
    logic [15:0] temp = 16'h0;
    logic [15:0] dpOut;
    logic [15:0] lastResult = 16'h0;

    cal_seq_if #(.NV_AW(4)) bus ();

    cal_seq #(.A2D_TMO(TMO), .NV_AW(4), .COEFF_BASE(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] satAdd(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Gain in unsigned Q8.8.
    function automatic logic [15:0] satMul(input logic [15:0] c, input logic [15:0] t);
        logic [31:0] p;
        p = ({16'h0, c} * {16'h0, t}) >> 8;
        return (p > 32'h0000FFFF) ? 16'hFFFF : p[15:0];
    endfunction

    // External datapath: NV_MEM with 1-cycle read, muxes, Temp register.
    always_comb begin
        dpOut = bus.selMult ? satMul(coeffQ, temp)
                            : satAdd(bus.selA2D ? a2d : temp, bus.selCoeff ? coeffQ : 16'h0);
    end
    assign bus.dst = dpOut;

    always_ff @(posedge clk) begin
        coeffQ <= nvMem[bus.nv_addr];
        if (rst) temp <= 16'h0;
        else if (bus.enTmp) temp <= dpOut;
    end

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: got %0h, expected %0h", tag, c, obs, exp);
        end
    endtask

    function automatic logic [3:0] ctrlObs();
        return {bus.selA2D, bus.selCoeff, bus.selMult, bus.enTmp};
    endfunction

    task automatic chkReset(input string tag);
        chk({tag, "_ctrl"}, 0, 32'(ctrlObs()), 32'h0);
        chk({tag, "_nv"}, 0, 32'(bus.nv_addr), 32'h0);
        chk({tag, "_busy"}, 0, 32'(bus.busy), 32'h0);
        chk({tag, "_rdy"}, 0, 32'(bus.rdy), 32'h0);
        chk({tag, "_err"}, 0, 32'(bus.err), 32'h0);
        chk({tag, "_scnv"}, 0, 32'(bus.strt_cnv), 32'h0);
        chk({tag, "_res"}, 0, 32'(bus.result), 32'h0);
    endtask

    // One calibrated conversion; cnv_cmplt in cycle k. Optional strt glitch,
    // back-to-back restart in the rdy cycle, or entry with strt already taken.
    task automatic seqRun(input int k, input logic [15:0] a, input logic [15:0] c0,
                          input logic [15:0] c1, input logic [15:0] c2,
                          input int glitchAt, input bit b2b, input bit started);
        logic [15:0] expOfs, expRes;
        logic [3:0]  expCtrl;
        logic [3:0]  expNv;
        expOfs = satAdd(a, c0);
        expRes = satAdd(satMul(c1, expOfs), c2);
        a2d = a;
        nvMem[0] = c0; nvMem[1] = c1; nvMem[2] = c2;
        if (!started) bus.strt = 1'b1;
        for (int c = 1; c <= k + 5; c++) begin
            if (!(started && c == 1)) step();
            bus.strt = 1'b0;
            bus.cnv_cmplt = (c == k);
            expCtrl = (c == k + 1) ? 4'b1101 : (c == k + 2) ? 4'b0011 :
                      (c == k + 3) ? 4'b0101 : 4'b0000;
            expNv   = (c == k + 1) ? 4'd1 : (c == k + 2) ? 4'd2 : 4'd0;
            chk("strt_cnv", c, 32'(bus.strt_cnv), 32'(c == 1 || (b2b && c == k + 5)));
            chk("busy", c, 32'(bus.busy), 32'((c <= k + 3) || (b2b && c == k + 5)));
            chk("ctrl", c, 32'(ctrlObs()), 32'(expCtrl));
            chk("nv_addr", c, 32'(bus.nv_addr), 32'(expNv));
            chk("rdy", c, 32'(bus.rdy), 32'(c == k + 4));
            chk("err", c, 32'(bus.err), 32'h0);
            if (c == k + 2) chk("temp_ofst", c, 32'(temp), 32'(expOfs));
            chk("result", c, 32'(bus.result), 32'((c >= k + 4) ? expRes : lastResult));
            if (c == glitchAt) bus.strt = 1'b1;
            if (b2b && c == k + 4) bus.strt = 1'b1;
        end
        bus.cnv_cmplt = 1'b0;
        lastResult = expRes;
        $display("seq k=%0d a2d=%h c=%h/%h/%h result=%h exp=%h", k, a, c0, c1, c2, bus.result, expRes);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) nvMem[i] = 16'h0;
        bus.strt = 1'b0;
        bus.cnv_cmplt = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        chkReset("reset");
        $display("reset released, outputs checked");

        // Nominal: strt at cycle 0, cnv_cmplt at cycle 3.
        seqRun(3, 16'h0100, 16'h0010, 16'h0200, 16'h0005, 0, 1'b0, 1'b0);

        // Timeout: no completion, err in cycle TMO+1, nothing else moves.
        bus.strt = 1'b1;
        for (int c = 1; c <= TMO + 3; c++) begin
            step();
            bus.strt = 1'b0;
            chk("tmo_err", c, 32'(bus.err), 32'(c == TMO + 1));
            chk("tmo_busy", c, 32'(bus.busy), 32'(c <= TMO));
            chk("tmo_rdy", c, 32'(bus.rdy), 32'h0);
            chk("tmo_enTmp", c, 32'(bus.enTmp), 32'h0);
            chk("tmo_result", c, 32'(bus.result), 32'(lastResult));
        end
        $display("timeout sequence: result held at %h", bus.result);

        // Completion coincident with the timeout cycle wins.
        seqRun(TMO, 16'h1234, 16'h0100, 16'h0180, 16'h0042, 0, 1'b0, 1'b0);

        // strt during GAIN (cycle k+2) is dropped.
        seqRun(2, 16'h0400, 16'h0020, 16'h0100, 16'h0001, 4, 1'b0, 1'b0);

        // Reset while in GAIN.
        bus.strt = 1'b1;
        step(); bus.strt = 1'b0; bus.cnv_cmplt = 1'b1;
        step(); bus.cnv_cmplt = 1'b0;
        step();
        chk("gain_ctrl", 3, 32'(ctrlObs()), 32'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chkReset("rst_gain");
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rst_gain_rdy", c, 32'(bus.rdy), 32'h0);
        end
        lastResult = 16'h0;
        $display("reset in GAIN: outputs back to reset values");

        // Fresh sequence after the mid-sequence reset, with back-to-back restart.
        seqRun(1, 16'hFF00, 16'h0200, 16'h0100, 16'h0003, 0, 1'b1, 1'b0);
        seqRun(2, 16'h0050, 16'h0005, 16'h0300, 16'h0010, 0, 1'b0, 1'b1);

        // Randomized sequences against the model.
        for (int n = 0; n < 6; n++) begin
            seqRun(int'($urandom_range(1, 7)), 16'($urandom), 16'($urandom),
                   16'($urandom_range(0, 16'h03FF)), 16'($urandom), 0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
